// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t     : loader sequencing states
//   depth_words : instruction-memory depth in words for a given byte-address width
//   NOP_INSTR   : filler instruction (addi x0,x0,0) for the core side
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int DEF_INS_ADDRESS = 9;

    // Word depth of a memory addressed with ins_address byte-address bits.
    function automatic int depth_words(input int ins_address);
        return 32'sd1 << (ins_address - 32'sd2);
    endfunction

    localparam int DEPTH = depth_words(DEF_INS_ADDRESS);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_xor_checksum.sv
// imem_xor_checksum
// Running XOR accumulator over the program image data words.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the accumulator (takes priority over enable)
//   enable     : fold data into the accumulator this cycle
//   data       : word to fold in
//   csum       : current running XOR
module imem_xor_checksum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data,
    output logic [W-1:0] csum
);

    // accumulate XOR of accepted data words
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= {W{1'b0}};
        end else if (clear) begin
            csum <= {W{1'b0}};
        end else if (enable) begin
            csum <= csum ^ data;
        end else begin
            csum <= csum;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Loads a program image (length word, N data words, XOR checksum word) from a
// valid/ready stream into instruction memory, keeping the core in reset until
// a good image has been written.
//   clk, reset     : clock, synchronous active-high reset
//   start          : one-cycle pulse, begins a load from IDLE, DONE or ERR
//   s_valid/s_ready/s_data : input word stream
//   mem_we/mem_wa/mem_wd   : instruction-memory write port (byte address)
//   core_reset     : holds the core and PC in reset
//   busy/done/error: load status
//   words_loaded   : data words written in the current load
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [INS_W-1:0]       s_data,
    output logic                   s_ready,
    output logic                   mem_we,
    output logic [INS_ADDRESS-1:0] mem_wa,
    output logic [INS_W-1:0]       mem_wd,
    output logic                   core_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [INS_ADDRESS-2:0] words_loaded
);

    localparam int MEM_DEPTH = depth_words(INS_ADDRESS);
    localparam int IW        = INS_ADDRESS - 2;   // word-index width

    state_t           state_r;
    logic [IW:0]      len_r;     // one bit wider than idx so DEPTH fits
    logic [IW-1:0]    idx_r;
    logic [INS_W-1:0] csum_s;
    logic             xfer_s;
    logic             len_bad_s;
    logic             last_data_s;
    logic             csum_clear_s;
    logic             csum_en_s;

    assign xfer_s       = s_valid && s_ready;
    assign len_bad_s    = (s_data == {INS_W{1'b0}}) || (s_data > INS_W'(MEM_DEPTH));
    assign last_data_s  = ({1'b0, idx_r} == (len_r - {{IW{1'b0}}, 1'b1}));
    assign csum_clear_s = (state_r == LEN) && xfer_s;
    assign csum_en_s    = (state_r == DATA) && xfer_s;

    imem_xor_checksum #(
        .W (INS_W)
    ) u_csum (
        .clk    (clk),
        .reset  (reset),
        .clear  (csum_clear_s),
        .enable (csum_en_s),
        .data   (s_data),
        .csum   (csum_s)
    );

    // load sequencer with registered stream, write-port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_wa       <= {INS_ADDRESS{1'b0}};
            mem_wd       <= {INS_W{1'b0}};
            core_reset   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= {(INS_ADDRESS-1){1'b0}};
            len_r        <= {(IW+1){1'b0}};
            idx_r        <= {IW{1'b0}};
        end else begin
            // write enable is a single-cycle pulse after each data transfer
            mem_we <= 1'b0;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        // core goes back into reset before any write can occur
                        state_r      <= LEN;
                        s_ready      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_reset   <= 1'b1;
                        words_loaded <= {(INS_ADDRESS-1){1'b0}};
                    end
                end
                LEN: begin
                    if (xfer_s) begin
                        if (len_bad_s) begin
                            state_r <= ERR;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            len_r   <= s_data[IW:0];
                            idx_r   <= {IW{1'b0}};
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer_s) begin
                        mem_we       <= 1'b1;
                        mem_wa       <= {idx_r, 2'b00};
                        mem_wd       <= s_data;
                        idx_r        <= idx_r + {{(IW-1){1'b0}}, 1'b1};
                        words_loaded <= words_loaded + {{(INS_ADDRESS-2){1'b0}}, 1'b1};
                        if (last_data_s) begin
                            state_r <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (xfer_s) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == csum_s) begin
                            state_r    <= DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state_r <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    s_ready    <= 1'b0;
                    busy       <= 1'b0;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Self-checking bench for imem_boot_loader: directed scenarios plus randomized
// images, judged against an image-level reference model.
module tb_imem_boot_loader;

    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_we;
    logic [8:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    int tests_run    = 0;
    int tests_failed = 0;

    bit          data_xfer_flag = 1'b0;
    logic [8:0]  got_addr[$];
    logic [31:0] got_data[$];

    always #5 clk = ~clk;

    imem_boot_loader #(
        .INS_ADDRESS (9),
        .INS_W       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mem_we       (mem_we),
        .mem_wa       (mem_wa),
        .mem_wd       (mem_wd),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // record writes; a write must appear exactly in the cycle after a data word was accepted
    always @(negedge clk) begin
        if (mem_we === 1'b1 || data_xfer_flag) begin
            tests_run++;
            if (mem_we !== data_xfer_flag) begin
                tests_failed++;
                $display("FAIL write_timing: mem_we=%b expected %b at t=%0t", mem_we, data_xfer_flag, $time);
            end
        end
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_wa);
            got_data.push_back(mem_wd);
        end
        data_xfer_flag = 1'b0;
    end

    // Image-level model: what gets written and how the load ends.
    function automatic void model_load(input word_q_t img, output bit ok, output bit err,
                                       output word_q_t wr);
        logic [31:0] x;
        int n;
        wr  = {};
        ok  = 1'b0;
        err = 1'b0;
        if (img[0] == 32'd0 || img[0] > 32'd128) begin
            err = 1'b1;
            return;
        end
        n = int'(img[0]);
        x = 32'd0;
        for (int k = 0; k < n; k++) begin
            wr.push_back(img[1+k]);
            x = x ^ img[1+k];
        end
        if (img[n+1] == x) ok = 1'b1;
        else err = 1'b1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer img word by word; words first_data..first_data+n_data-1 are data words.
    task automatic drive_stream(input word_q_t img, input int first_data, input int n_data,
                                input int stall_mode);
        int i   = 0;
        int cyc = 0;
        bit v;
        bit rdy;
        while (i < img.size()) begin
            @(negedge clk);
            rdy = s_ready;
            case (stall_mode)
                1:       v = (cyc % 3) != 2;
                2:       v = $urandom_range(0, 3) != 0;
                default: v = 1'b1;
            endcase
            s_valid = v;
            s_data  = v ? img[i] : $urandom;
            @(posedge clk);
            if (v && rdy) begin
                if (i >= first_data && i < first_data + n_data) data_xfer_flag = 1'b1;
                i++;
            end
            cyc++;
            if (cyc > 2000) begin
                tests_run++;
                tests_failed++;
                $display("FAIL stream_timeout: accepted %0d words, required %0d", i, img.size());
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({s_ready, mem_we, mem_wa, mem_wd} !== {1'b0, 1'b0, 9'h000, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_port: s_ready=%b mem_we=%b mem_wa=%h mem_wd=%h, required 0", s_ready, mem_we, mem_wa, mem_wd);
        end
        tests_run++;
        if ({core_reset, busy, done, error, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_status: core_reset=%b busy=%b done=%b error=%b words=%0d, required 1/0/0/0/0",
                     core_reset, busy, done, error, words_loaded);
        end
        // start together with reset: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        tests_run++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wins: s_ready=%b busy=%b, required 0/0", s_ready, busy);
        end
    endtask

    task automatic test_nominal();
        word_q_t img, exp_wr;
        bit ok, err;
        img = {32'd3, 32'h00100093, 32'h00200113, 32'h00308193, 32'h00008013};
        model_load(img, ok, err, exp_wr);
        apply_reset();
        got_addr.delete();
        got_data.delete();
        pulse_start();
        tests_run++;
        if (s_ready !== 1'b1 || busy !== 1'b1 || core_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL nominal_start: s_ready=%b busy=%b core_reset=%b, required 1/1/1", s_ready, busy, core_reset);
        end
        drive_stream(img, 1, 3, 0);
        tests_run++;
        if (got_data.size() != exp_wr.size()) begin
            tests_failed++;
            $display("FAIL nominal_count: %0d writes, required %0d", got_data.size(), exp_wr.size());
        end else begin
            for (int k = 0; k < exp_wr.size(); k++) begin
                tests_run++;
                if (got_addr[k] !== 9'(4*k) || got_data[k] !== exp_wr[k]) begin
                    tests_failed++;
                    $display("FAIL nominal_write%0d: %h@%h, required %h@%h", k, got_data[k], got_addr[k], exp_wr[k], 9'(4*k));
                end
            end
        end
        tests_run++;
        if (done !== ok || error !== err || core_reset !== !ok || words_loaded !== 8'd3 || s_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_end: done=%b error=%b core_reset=%b words=%0d s_ready=%b busy=%b, required %b/%b/%b/3/0/0",
                     done, error, core_reset, words_loaded, s_ready, busy, ok, err, !ok);
        end
    endtask

    task automatic test_bad_length();
        logic [31:0] lens[2];
        lens[0] = 32'd129;
        lens[1] = 32'd0;
        for (int j = 0; j < 2; j++) begin
            apply_reset();
            got_addr.delete();
            got_data.delete();
            pulse_start();
            drive_stream({lens[j]}, 1, 0, 0);
            repeat (3) @(negedge clk);
            tests_run++;
            if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0
                || got_data.size() != 0) begin
                tests_failed++;
                $display("FAIL bad_length_%0d: error=%b done=%b core_reset=%b busy=%b s_ready=%b writes=%0d, required 1/0/1/0/0/0",
                         lens[j], error, done, core_reset, busy, s_ready, got_data.size());
            end
        end
    endtask

    task automatic test_bad_checksum();
        word_q_t img, exp_wr;
        bit ok, err;
        img = {32'd3, 32'h00100093, 32'h00200113, 32'h00308193, 32'h00008012};
        model_load(img, ok, err, exp_wr);
        apply_reset();
        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_stream(img, 1, 3, 0);
        tests_run++;
        if (got_data.size() != exp_wr.size()) begin
            tests_failed++;
            $display("FAIL badsum_count: %0d writes, required %0d", got_data.size(), exp_wr.size());
        end else begin
            for (int k = 0; k < exp_wr.size(); k++) begin
                tests_run++;
                if (got_addr[k] !== 9'(4*k) || got_data[k] !== exp_wr[k]) begin
                    tests_failed++;
                    $display("FAIL badsum_write%0d: %h@%h, required %h@%h", k, got_data[k], got_addr[k], exp_wr[k], 9'(4*k));
                end
            end
        end
        tests_run++;
        if (error !== err || done !== ok || core_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL badsum_end: error=%b done=%b core_reset=%b, required %b/%b/1", error, done, core_reset, err, ok);
        end
    endtask

    task automatic test_full_depth();
        word_q_t img, exp_wr;
        bit ok, err;
        logic [31:0] x;
        img = {32'd128};
        x   = 32'd0;
        for (int k = 0; k < 128; k++) begin
            img.push_back(32'(k));
            x = x ^ 32'(k);
        end
        img.push_back(x);
        model_load(img, ok, err, exp_wr);
        apply_reset();
        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_stream(img, 1, 128, 1);
        tests_run++;
        if (got_data.size() != 128) begin
            tests_failed++;
            $display("FAIL full_count: %0d writes, required 128", got_data.size());
        end else begin
            for (int k = 0; k < 128; k++) begin
                tests_run++;
                if (got_addr[k] !== 9'(4*k) || got_data[k] !== exp_wr[k]) begin
                    tests_failed++;
                    $display("FAIL full_write%0d: %h@%h, required %h@%h", k, got_data[k], got_addr[k], exp_wr[k], 9'(4*k));
                end
            end
            tests_run++;
            if (got_addr[127] !== 9'h1FC) begin
                tests_failed++;
                $display("FAIL full_last_addr: %h, required 1fc", got_addr[127]);
            end
        end
        tests_run++;
        if (done !== ok || error !== err || words_loaded !== 8'd128 || core_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_end: done=%b error=%b words=%0d core_reset=%b, required 1/0/128/0", done, error, words_loaded, core_reset);
        end
    endtask

    task automatic test_reset_mid_data();
        word_q_t img;
        img = {32'd3, 32'h00100093, 32'h00200113, 32'h00308193, 32'h00008013};
        apply_reset();
        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_stream({img[0], img[1], img[2]}, 1, 2, 0);
        apply_reset();
        tests_run++;
        if ({s_ready, mem_we, mem_wa, mem_wd, core_reset, busy, done, error, words_loaded}
            !== {1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL midreset_state: s_ready=%b mem_we=%b wa=%h wd=%h core_reset=%b busy=%b done=%b error=%b words=%0d",
                     s_ready, mem_we, mem_wa, mem_wd, core_reset, busy, done, error, words_loaded);
        end
        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_stream(img, 1, 3, 2);
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || got_data.size() != 3 || words_loaded !== 8'd3) begin
            tests_failed++;
            $display("FAIL midreset_reload: done=%b error=%b writes=%0d words=%0d, required 1/0/3/3",
                     done, error, got_data.size(), words_loaded);
        end
    endtask

    task automatic test_start_ignored_reload();
        word_q_t img;
        img = {32'd3, 32'h00100093, 32'h00200113, 32'h00308193, 32'h00008013};
        apply_reset();
        got_addr.delete();
        got_data.delete();
        pulse_start();
        drive_stream({img[0], img[1]}, 1, 1, 0);
        pulse_start();
        tests_run++;
        if (words_loaded !== 8'd1 || busy !== 1'b1 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start: words=%0d busy=%b s_ready=%b, required 1/1/1", words_loaded, busy, s_ready);
        end
        drive_stream({img[2], img[3], img[4]}, 0, 2, 0);
        tests_run++;
        if (done !== 1'b1 || core_reset !== 1'b0 || got_data.size() != 3) begin
            tests_failed++;
            $display("FAIL busy_start_load: done=%b core_reset=%b writes=%0d, required 1/0/3", done, core_reset, got_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (got_addr[k] !== 9'(4*k) || got_data[k] !== img[k+1]) begin
                    tests_failed++;
                    $display("FAIL busy_start_write%0d: %h@%h, required %h@%h", k, got_data[k], got_addr[k], img[k+1], 9'(4*k));
                end
            end
        end
        pulse_start();
        tests_run++;
        if (core_reset !== 1'b1 || done !== 1'b0 || words_loaded !== 8'd0 || s_ready !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_start: core_reset=%b done=%b words=%0d s_ready=%b busy=%b, required 1/0/0/1/1",
                     core_reset, done, words_loaded, s_ready, busy);
        end
    endtask

    task automatic test_random_images();
        word_q_t img, exp_wr;
        bit ok, err;
        logic [31:0] x;
        int n;
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            img = {};
            if ($urandom_range(0, 7) == 0) begin
                img.push_back(($urandom_range(0, 1) == 0) ? 32'd0 : 32'(129 + $urandom_range(0, 1000)));
                n = 0;
            end else begin
                n = $urandom_range(1, 12);
                img.push_back(32'(n));
                x = 32'd0;
                for (int k = 0; k < n; k++) begin
                    img.push_back($urandom);
                    x = x ^ img[k+1];
                end
                img.push_back(($urandom_range(0, 2) == 0) ? (x ^ (32'd1 << $urandom_range(0, 31))) : x);
            end
            model_load(img, ok, err, exp_wr);
            got_addr.delete();
            got_data.delete();
            pulse_start();
            drive_stream(img, 1, n, 2);
            tests_run++;
            if (got_data.size() != exp_wr.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_count: %0d writes, required %0d", it, got_data.size(), exp_wr.size());
            end else begin
                for (int k = 0; k < exp_wr.size(); k++) begin
                    tests_run++;
                    if (got_addr[k] !== 9'(4*k) || got_data[k] !== exp_wr[k]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_write%0d: %h@%h, required %h@%h", it, k, got_data[k], got_addr[k], exp_wr[k], 9'(4*k));
                    end
                end
            end
            tests_run++;
            if (done !== ok || error !== err || core_reset !== !ok || busy !== 1'b0 || words_loaded !== 8'(exp_wr.size())) begin
                tests_failed++;
                $display("FAIL rand%0d_end: done=%b error=%b core_reset=%b busy=%b words=%0d, required %b/%b/%b/0/%0d",
                         it, done, error, core_reset, busy, words_loaded, ok, err, !ok, exp_wr.size());
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_nominal();
        test_bad_length();
        test_bad_checksum();
        test_full_depth();
        test_reset_mid_data();
        test_start_ignored_reload();
        test_random_images();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
